ram_arbiter: RTL and testbench

//  Shares the single read/write port of the 48K Spectrum RAM between three requesters: video fetch,
//  Z80 CPU and the snapshot/tape loader. Sits between the requesters and the RAM's port A.

---
 rtl/ram_arbiter_if.sv | 47 ++++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM port-A signal bundle for ram_arbiter.
// slave = arbiter side, master = requesters plus RAM model side.
interface ram_arbiter_if;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_ack;
    logic [7:0]  vid_data;

    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    logic        ld_req;
    logic [15:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_ack;

    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_addr, ld_wdata,
        input  mem_dout,
        output vid_ack, vid_data,
        output cpu_ack, cpu_rdata,
        output ld_ack,
        output mem_we, mem_addr, mem_din
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_addr, ld_wdata,
        output mem_dout,
        input  vid_ack, vid_data,
        input  cpu_ack, cpu_rdata,
        input  ld_ack,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the 48K Spectrum RAM port between video, CPU and loader.
// Grant is registered; the ack pulses two cycles later with the read data.
module ram_arbiter #(
    parameter logic [15:0] RAM_BASE     = 16'h4000,
    parameter int unsigned RAM_SIZE     = 49152,
    parameter int unsigned CPU_MAX_WAIT = 4,
    parameter logic [7:0]  ROM_RD_VALUE = 8'hFF
) (
    input logic          clk,
    input logic          reset,
    ram_arbiter_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {SRC_NONE, SRC_VID, SRC_CPU, SRC_LD} src_t;
    typedef enum logic {LAST_CPU, LAST_LD} last_t;

    src_t              grant;
    src_t              issue_src;
    src_t              ack_src;
    logic              issue_oor, ack_oor;
    logic              issue_rd, ack_rd;
    last_t             last_served;
    logic [WAIT_W-1:0] cpu_wait;
    logic [7:0]        vid_data_q, cpu_rdata_q;
    logic              mem_we_q;
    logic [15:0]       mem_addr_q;
    logic [7:0]        mem_din_q;

    logic [15:0] cpu_off, ld_off;
    logic        cpu_in_range, ld_in_range;
    logic        vid_elig, cpu_elig, ld_elig;

    assign cpu_off      = bus.cpu_addr - RAM_BASE;
    assign ld_off       = bus.ld_addr - RAM_BASE;
    assign cpu_in_range = (bus.cpu_addr >= RAM_BASE) && (32'(cpu_off) < RAM_SIZE);
    assign ld_in_range  = (bus.ld_addr >= RAM_BASE) && (32'(ld_off) < RAM_SIZE);

    // A requester stays blocked from issue until its ack cycle has passed
    assign vid_elig = bus.vid_req && (issue_src != SRC_VID) && (ack_src != SRC_VID);
    assign cpu_elig = bus.cpu_req && (issue_src != SRC_CPU) && (ack_src != SRC_CPU);
    assign ld_elig  = bus.ld_req  && (issue_src != SRC_LD)  && (ack_src != SRC_LD);

    always_comb begin
        grant = SRC_NONE;
        if (cpu_elig && (cpu_wait == WAIT_MAX))
            grant = SRC_CPU;
        else if (vid_elig)
            grant = SRC_VID;
        else if (cpu_elig && ld_elig)
            grant = (last_served == LAST_CPU) ? SRC_LD : SRC_CPU;
        else if (cpu_elig)
            grant = SRC_CPU;
        else if (ld_elig)
            grant = SRC_LD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_src   <= SRC_NONE;
            ack_src     <= SRC_NONE;
            issue_oor   <= 1'b0;
            ack_oor     <= 1'b0;
            issue_rd    <= 1'b0;
            ack_rd      <= 1'b0;
            last_served <= LAST_LD;
            cpu_wait    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            issue_src <= grant;
            ack_src   <= issue_src;
            issue_oor <= (grant == SRC_CPU) && !cpu_in_range;
            ack_oor   <= issue_oor;
            issue_rd  <= (grant == SRC_CPU) && !bus.cpu_we;
            ack_rd    <= issue_rd;
            mem_we_q  <= 1'b0;

            // Out-of-range accesses leave mem_addr/mem_din untouched
            unique case (grant)
                SRC_VID: mem_addr_q <= bus.vid_addr;
                SRC_CPU: begin
                    last_served <= LAST_CPU;
                    if (cpu_in_range) begin
                        mem_addr_q <= cpu_off;
                        mem_we_q   <= bus.cpu_we;
                        if (bus.cpu_we)
                            mem_din_q <= bus.cpu_wdata;
                    end
                end
                SRC_LD: begin
                    last_served <= LAST_LD;
                    if (ld_in_range) begin
                        mem_addr_q <= ld_off;
                        mem_we_q   <= 1'b1;
                        mem_din_q  <= bus.ld_wdata;
                    end
                end
                default: ;
            endcase

            if (grant == SRC_CPU)
                cpu_wait <= '0;
            else if (cpu_elig && (cpu_wait != WAIT_MAX))
                cpu_wait <= cpu_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            if (bus.vid_ack)
                vid_data_q <= bus.mem_dout;
            if (bus.cpu_ack && ack_rd)
                cpu_rdata_q <= ack_oor ? ROM_RD_VALUE : bus.mem_dout;
        end
    end

    assign bus.vid_ack   = (ack_src == SRC_VID);
    assign bus.cpu_ack   = (ack_src == SRC_CPU);
    assign bus.ld_ack    = (ack_src == SRC_LD);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    // Read data is passed straight through in the ack cycle, held afterwards
    assign bus.vid_data  = bus.vid_ack ? bus.mem_dout : vid_data_q;
    assign bus.cpu_rdata = (bus.cpu_ack && ack_rd) ? (ack_oor ? ROM_RD_VALUE : bus.mem_dout)
                                                   : cpu_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vectors, corner sequences
// and randomized traffic against a reference memory model.
module tb_ram_arbiter;
    localparam int RAM_DEPTH = 49152;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter #(
        .RAM_BASE    (16'h4000),
        .RAM_SIZE    (49152),
        .CPU_MAX_WAIT(4),
        .ROM_RD_VALUE(8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [7:0] init_val(input int i);
        return (i == 0) ? 8'h3C : 8'(i * 7 + 3);
    endfunction

    // Synchronous RAM environment, preloaded on the first clock
    logic [7:0] ram [0:RAM_DEPTH-1];
    logic       ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= ram[bus.mem_addr];
        end
    end

    logic [7:0] ref_mem [0:RAM_DEPTH-1];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_ram(input logic [15:0] a);
        return (int'(a) >= 16'h4000) && (int'(a) - 16'h4000 < RAM_DEPTH);
    endfunction

    function automatic int offs(input logic [15:0] a);
        return int'(a) - 16'h4000;
    endfunction

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        exp_we;
        logic        chk_addr;
        logic [15:0] exp_maddr;
        logic [7:0]  exp_rdata;
    } vec_t;

    task automatic cpu_access(input string tag, input logic [15:0] addr, input logic we,
                              input logic [7:0] wd, input logic exp_we, input logic chk_addr,
                              input logic [15:0] exp_maddr, input logic [7:0] exp_rd);
        int   lat;
        logic saw_we;
        logic got;
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_we    = we;
        bus.cpu_wdata = wd;
        bus.cpu_req   = 1'b1;
        lat = 0; saw_we = 1'b0; got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1 && chk_addr) chk({tag, " mem_addr"}, int'(bus.mem_addr), int'(exp_maddr));
            if (bus.mem_we) saw_we = 1'b1;
            if (bus.cpu_ack) got = 1'b1;
        end
        chk({tag, " latency"}, lat, 2);
        chk({tag, " mem_we"}, int'(saw_we), int'(exp_we));
        if (!we) chk({tag, " rdata"}, int'(bus.cpu_rdata), int'(exp_rd));
        if (we && in_ram(addr)) ref_mem[offs(addr)] = wd;
        bus.cpu_req = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [7:0] old;
        bit         flag;
        int         vid_acks, cpu_at, cyc;
        string      prev, cur;
        bit         vid_pend, cpu_pend, ld_pend;
        int         vid_age, cpu_age, ld_age;
        logic [15:0] va, ca, la;
        logic        cw;
        logic [7:0]  cd, ld_d;
        bit          ok;

        for (int i = 0; i < RAM_DEPTH; i++) ref_mem[i] = init_val(i);
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset acks", int'({bus.vid_ack, bus.cpu_ack, bus.ld_ack}), 0);
        chk("reset mem_we", int'(bus.mem_we), 0);
        chk("reset mem_addr", int'(bus.mem_addr), 0);
        chk("reset mem_din", int'(bus.mem_din), 0);
        chk("reset vid_data", int'(bus.vid_data), 0);
        chk("reset cpu_rdata", int'(bus.cpu_rdata), 0);
        reset = 1'b0;

        vecs.push_back('{"rd 4000",  16'h4000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h3C});
        vecs.push_back('{"wr FFFF",  16'hFFFF, 1'b1, 8'hA5, 1'b1, 1'b1, 16'hBFFF, 8'h00});
        vecs.push_back('{"rd FFFF",  16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b1, 16'hBFFF, 8'hA5});
        vecs.push_back('{"rd 1234",  16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hFF});
        vecs.push_back('{"wr 3FFF",  16'h3FFF, 1'b1, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00});
        vecs.push_back('{"rd 3FFF",  16'h3FFF, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hFF});
        vecs.push_back('{"wr 8000",  16'h8000, 1'b1, 8'h5A, 1'b1, 1'b1, 16'h4000, 8'h00});
        vecs.push_back('{"rd 8000",  16'h8000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h4000, 8'h5A});
        vecs.push_back('{"wr 4000",  16'h4000, 1'b1, 8'h11, 1'b1, 1'b1, 16'h0000, 8'h00});
        vecs.push_back('{"rd 4000b", 16'h4000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h11});
        foreach (vecs[i])
            cpu_access(vecs[i].name, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].exp_we,
                       vecs[i].chk_addr, vecs[i].exp_maddr, vecs[i].exp_rdata);

        // Video requesting continuously while a CPU read waits
        @(negedge clk);
        bus.vid_addr = 16'h0010; bus.vid_req = 1'b1;
        bus.cpu_addr = 16'h4005; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
        vid_acks = 0; cpu_at = -1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (bus.vid_ack) begin
                vid_acks++;
                chk("aging vid_data", int'(bus.vid_data), int'(ref_mem[16]));
            end
            if (bus.cpu_ack && cpu_at < 0) begin
                cpu_at = c;
                chk("aging cpu_rdata", int'(bus.cpu_rdata), int'(ref_mem[5]));
                bus.cpu_req = 1'b0;
            end
        end
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
        chk("aging cpu served", int'(cpu_at > 0 && cpu_at <= 4 + 2), 1);
        chk("aging vid keeps going", int'(vid_acks >= 4), 1);
        repeat (3) @(negedge clk);

        // CPU and loader both requesting back to back
        bus.cpu_addr = 16'h4000; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
        bus.ld_addr = 16'h6000; bus.ld_wdata = 8'h40; bus.ld_req = 1'b1;
        prev = "";
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            cur = "";
            if (bus.cpu_ack) begin
                cur = "C";
                chk("alt cpu_rdata", int'(bus.cpu_rdata), int'(ref_mem[0]));
            end
            if (bus.ld_ack) begin
                cur = "L";
                ref_mem[16'h2000] = bus.ld_wdata;
                bus.ld_wdata = bus.ld_wdata + 8'd1;
            end
            if (cur != "") begin
                if (prev != "") chk("alt order", int'(cur != prev), 1);
                prev = cur;
            end
        end
        bus.cpu_req = 1'b0; bus.ld_req = 1'b0;
        repeat (3) @(negedge clk);
        cpu_access("ld readback", 16'h6000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h2000, ref_mem[16'h2000]);

        // Reset between grant and ack drops the access
        old = ref_mem[16'h0100];
        @(negedge clk);
        bus.cpu_addr = 16'h4100; bus.cpu_we = 1'b1; bus.cpu_wdata = ~old; bus.cpu_req = 1'b1;
        @(negedge clk);
        chk("rst mid mem_we before", int'(bus.mem_we), 1);
        reset = 1'b1;
        #1;
        chk("rst mid mem_we after", int'(bus.mem_we), 0);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.vid_ack || bus.ld_ack) flag = 1'b1;
        end
        chk("rst mid no ack", int'(flag), 0);
        cpu_access("rst readback", 16'h4100, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0100, old);

        // Randomized traffic from all three requesters
        vid_pend = 0; cpu_pend = 0; ld_pend = 0;
        vid_age = 0; cpu_age = 0; ld_age = 0;
        va = '0; ca = '0; la = '0; cw = 1'b0; cd = '0; ld_d = '0;
        for (cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                ok = (cpu_pend && cw && in_ram(ca) && int'(bus.mem_addr) == offs(ca) && bus.mem_din == cd)
                  || (ld_pend && in_ram(la) && int'(bus.mem_addr) == offs(la) && bus.mem_din == ld_d);
                chk("rnd mem_we legal", int'(ok), 1);
            end
            if ($countones({bus.vid_ack, bus.cpu_ack, bus.ld_ack}) > 1)
                chk("rnd ack onehot", $countones({bus.vid_ack, bus.cpu_ack, bus.ld_ack}), 1);
            if (bus.vid_ack) begin
                chk("rnd vid pending", int'(vid_pend), 1);
                chk("rnd vid_data", int'(bus.vid_data), int'(ref_mem[va]));
                vid_pend = 0; bus.vid_req = 1'b0;
            end
            if (bus.cpu_ack) begin
                chk("rnd cpu pending", int'(cpu_pend), 1);
                if (!cw) chk("rnd cpu_rdata", int'(bus.cpu_rdata),
                             in_ram(ca) ? int'(ref_mem[offs(ca)]) : 255);
                else if (in_ram(ca)) ref_mem[offs(ca)] = cd;
                cpu_pend = 0; bus.cpu_req = 1'b0;
            end
            if (bus.ld_ack) begin
                chk("rnd ld pending", int'(ld_pend), 1);
                if (in_ram(la)) ref_mem[offs(la)] = ld_d;
                ld_pend = 0; bus.ld_req = 1'b0;
            end
            if (vid_pend && ++vid_age > 12) begin
                chk("rnd vid timeout", vid_age, 0); vid_pend = 0; bus.vid_req = 1'b0;
            end
            if (cpu_pend && ++cpu_age > 12) begin
                chk("rnd cpu timeout", cpu_age, 0); cpu_pend = 0; bus.cpu_req = 1'b0;
            end
            if (ld_pend && ++ld_age > 12) begin
                chk("rnd ld timeout", ld_age, 0); ld_pend = 0; bus.ld_req = 1'b0;
            end
            if (!vid_pend && $urandom_range(0, 2) == 0) begin
                va = 16'($urandom_range(0, 63));
                bus.vid_addr = va; bus.vid_req = 1'b1; vid_pend = 1; vid_age = 0;
            end
            if (!cpu_pend && $urandom_range(0, 1) == 0) begin
                ca = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 16'h3FFF))
                                                 : 16'h4000 + 16'($urandom_range(0, 63));
                cw = 1'($urandom);
                cd = 8'($urandom);
                bus.cpu_addr = ca; bus.cpu_we = cw; bus.cpu_wdata = cd;
                bus.cpu_req = 1'b1; cpu_pend = 1; cpu_age = 0;
            end
            if (!ld_pend && $urandom_range(0, 1) == 0) begin
                la = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 16'h3FFF))
                                                 : 16'h4000 + 16'($urandom_range(0, 63));
                ld_d = 8'($urandom);
                bus.ld_addr = la; bus.ld_wdata = ld_d;
                bus.ld_req = 1'b1; ld_pend = 1; ld_age = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
